mips_control_unit: RTL and testbench

- Main decoder for the single-issue MIPS-subset datapath.
- Takes the instruction opcode and function fields and produces the datapath steering signals and the 3-bit ALU operation select.
- Outputs are registered: one-cycle decode latency, cleared by asynchronous active-low reset.
- Sits between instruction fetch/IR and the register file, ALU and data memory.

---
 rtl/mips_control_unit.sv | 83 ++++++++
 tb/tb_mips_control_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_control_unit.sv
// Main decoder for the MIPS-subset datapath: registers the control word and
// ALU select decoded from op/func, one cycle after the inputs are presented.
module mips_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       Branch,
  output logic [2:0] ALU_op,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;

  // Control word: {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALU_op, illegal}
  logic [10:0] ctrl_d;
  logic [10:0] ctrl_q;

  // Decode op/func; unknown or X inputs fall through to the NOP/illegal word
  always_comb begin
    ctrl_d = 11'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  ctrl_d = {7'b1100000, ALU_ADD, 1'b0};
          FN_SUB:  ctrl_d = {7'b1100000, ALU_SUB, 1'b0};
          FN_AND:  ctrl_d = {7'b1100000, ALU_AND, 1'b0};
          FN_OR:   ctrl_d = {7'b1100000, ALU_OR,  1'b0};
          FN_XOR:  ctrl_d = {7'b1100000, ALU_XOR, 1'b0};
          default: ctrl_d = {7'b0000000, ALU_ADD, 1'b1};
        endcase
      end
      OP_LW:   ctrl_d = {7'b0110110, ALU_ADD, 1'b0};
      OP_SW:   ctrl_d = {7'b0011000, ALU_ADD, 1'b0};
      OP_BEQ:  ctrl_d = {7'b0000001, ALU_SUB, 1'b0};
      OP_LUI:  ctrl_d = {7'b0110000, ALU_LUI, 1'b0};
      default: ctrl_d = {7'b0000000, ALU_ADD, 1'b1};
    endcase
  end

  // Output register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 11'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign RegDst   = ctrl_q[10];
  assign RegWrite = ctrl_q[9];
  assign ALUSrc   = ctrl_q[8];
  assign MemWrite = ctrl_q[7];
  assign MemRead  = ctrl_q[6];
  assign MemtoReg = ctrl_q[5];
  assign Branch   = ctrl_q[4];
  assign ALU_op   = ctrl_q[3:1];
  assign illegal  = ctrl_q[0];

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: directed decode cases, async reset,
// and randomized op/func checked every cycle against a rule-based model.
module tb_mips_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, illegal;
  logic [2:0] ALU_op;

  int checks = 0;
  int errors = 0;

  int rfuncs [5] = '{32, 34, 36, 37, 38};
  int legal_ops [5] = '{0, 35, 43, 4, 15};

  logic       samp_valid = 1'b0;
  logic [5:0] samp_op = 6'd0;
  logic [5:0] samp_func = 6'd0;

  mips_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .Branch(Branch), .ALU_op(ALU_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] dut_word();
    return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALU_op, illegal};
  endfunction

  // Rule-level reference: what each instruction class must drive
  function automatic logic [10:0] model(input logic [5:0] o, input logic [5:0] f);
    bit rd, rw, as, mw, mr, m2r, br, ill;
    int alu;
    int idx;
    rd = 0; rw = 0; as = 0; mw = 0; mr = 0; m2r = 0; br = 0; ill = 0; alu = 0;
    if (o == 6'd0) begin
      idx = -1;
      for (int i = 0; i < 5; i++) if (int'(f) == rfuncs[i]) idx = i;
      if (idx < 0) ill = 1;
      else begin rd = 1; rw = 1; alu = idx; end
    end else if (o == 6'd35) begin
      rw = 1; as = 1; mr = 1; m2r = 1;
    end else if (o == 6'd43) begin
      as = 1; mw = 1;
    end else if (o == 6'd4) begin
      br = 1; alu = 1;
    end else if (o == 6'd15) begin
      rw = 1; as = 1; alu = 5;
    end else begin
      ill = 1;
    end
    return {rd, rw, as, mw, mr, m2r, br, 3'(alu), ill};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Capture the inputs the DUT decodes at each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_valid <= 1'b0;
    else begin
      samp_valid <= 1'b1;
      samp_op    <= op;
      samp_func  <= func;
    end
  end

  // Per-cycle comparison against the model plus invariants
  always @(negedge clk) begin
    logic [10:0] exp;
    exp = samp_valid ? model(samp_op, samp_func) : 11'd0;
    chk("cycle", dut_word(), exp);
    chk("inv_mw_mr", {10'd0, MemWrite & MemRead}, 11'd0);
    chk("inv_mw_rw", {10'd0, MemWrite & RegWrite}, 11'd0);
    chk("inv_br", {10'd0, Branch & (RegWrite | MemWrite)}, 11'd0);
  end

  task automatic apply(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic [10:0] exp);
    @(negedge clk); #1;
    op = o; func = f;
    @(posedge clk); #1;
    chk(name, dut_word(), exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    // Model pins, hand-derived
    chk("model_add", model(6'd0, 6'd32), 11'b1100000_000_0);
    chk("model_lw",  model(6'd35, 6'd38), 11'b0110110_000_0);
    chk("model_lui", model(6'd15, 6'd0), 11'b0110000_101_0);

    // Inputs toggling under reset must not reach the outputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      op = (i % 2 == 0) ? 6'd35 : 6'd0; func = 6'd32;
      @(posedge clk); #1;
      chk("reset_hold", dut_word(), 11'd0);
    end
    @(negedge clk); #1;
    op = 6'd0; func = 6'b100000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_add", dut_word(), 11'b1100000_000_0);

    apply("r_sub", 6'b000000, 6'b100010, 11'b1100000_001_0);
    apply("r_and", 6'b000000, 6'b100100, 11'b1100000_010_0);
    apply("r_or",  6'b000000, 6'b100101, 11'b1100000_011_0);
    apply("r_xor", 6'b000000, 6'b100110, 11'b1100000_100_0);
    apply("lw",    6'b100011, 6'b100110, 11'b0110110_000_0);
    apply("sw",    6'b101011, 6'b100110, 11'b0011000_000_0);
    apply("beq",   6'b000100, 6'b100110, 11'b0000001_001_0);
    apply("lui",   6'b001111, 6'b100110, 11'b0110000_101_0);
    apply("ill_fn", 6'b000000, 6'b000001, 11'b0000000_000_1);
    apply("ill_op", 6'b111111, 6'b100110, 11'b0000000_000_1);
    apply("ill_clr", 6'b100011, 6'b100110, 11'b0110110_000_0);

    // Async reset between edges during an lw decode
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_word(), 11'd0);
    @(negedge clk); #1;
    chk("async_hold", dut_word(), 11'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_lw", dut_word(), 11'b0110110_000_0);

    // Randomized mix of legal and arbitrary encodings
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      op   = ($urandom_range(1, 0) == 1) ? 6'(legal_ops[$urandom_range(4, 0)]) : 6'($urandom);
      func = ($urandom_range(1, 0) == 1) ? 6'(rfuncs[$urandom_range(4, 0)]) : 6'($urandom);
    end
    @(negedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
